poly_power2round_recombine: RTL and testbench

- Inverse of the polynomial Power2Round split: rebuilds each coefficient as a = a1*2^D + a0 from a packed (a1, a0) polynomial pair.
- Serves the verify/sign path, where t1*2^D (a0 = 0) or the full t is needed again from its split halves.
- Sequential and area-bounded: processes LANES coefficients per cycle instead of instantiating N combinational units.
- Uses valid/ready handshakes on both sides. Packed bus format matches the split block: coefficient x occupies bits [32x+31:32x], two's-complement signed.

---
 rtl/poly_power2round_recombine.sv | 167 ++++++++++++++++
 tb/tb_poly_power2round_recombine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_power2round_recombine.sv
// poly_power2round_recombine
//
// Rebuilds every coefficient of a polynomial as a = (a1 <<< D) + a0 from a
// packed (a1, a0) pair. This is the inverse of the Power2Round split. LANES
// coefficients are recombined per clock, so one polynomial takes N/LANES
// cycles in RUN, followed by a DONE state that holds the result until the
// output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a0_in / a1_in hold a valid polynomial pair
//   in_ready   block can accept a pair (IDLE only)
//   a0_in      packed signed low parts, coefficient x at [32x+31:32x]
//   a1_in      packed signed high parts, same packing
//   out_valid  a_out holds a complete result (DONE)
//   out_ready  downstream accepts a_out
//   a_out      packed signed recombined coefficients
//   busy       high in RUN or DONE
//   range_err  only when P2R_RANGE_CHECK_EN is defined; flags an a1 or a0
//              outside the legal Power2Round range, shown with out_valid
//
// Optional feature macro: P2R_RANGE_CHECK_EN

module poly_power2round_recombine #(
  parameter int N     = 256,
  parameter int LANES = 8,
  parameter int D     = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*N-1:0] a0_in,
  input  logic [32*N-1:0] a1_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*N-1:0] a_out,
  output logic            busy
`ifdef P2R_RANGE_CHECK_EN
  ,
  output logic            range_err
`endif
);

  localparam int STEPS = N / LANES;
  localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     idx;
  logic [32*N-1:0]   a0_buf;
  logic [32*N-1:0]   a1_buf;
  logic              accept;
  logic              last_step;
  int                base;
  logic signed [31:0] lane_a0  [LANES];
  logic signed [31:0] lane_a1  [LANES];
  logic        [31:0] lane_sum [LANES];

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (idx == IW'(STEPS - 1));
  assign base      = int'(idx) * LANES;

  // Slice out the LANES coefficient pairs addressed by idx and recombine
  // them. The shift and add are done at 32 bits, so the result wraps
  // modulo 2^32 with no saturation or mod-Q reduction.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_a0[j]  = a0_buf[32*(base + j) +: 32];
      lane_a1[j]  = a1_buf[32*(base + j) +: 32];
      lane_sum[j] = (lane_a1[j] <<< D) + lane_a0[j];
    end
  end

  // Next-state and handshake outputs. in_ready is only high in IDLE.
  // Because of this, a new pair can never be taken on the same edge as
  // the output handshake.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, input capture and lane write-back. The operands are
  // captured on accept so the producer may change its bus immediately.
  // a_out is only written in RUN. Coefficients not yet rewritten keep
  // their values from the previous polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      a0_buf  <= '0;
      a1_buf  <= '0;
      a_out   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a0_buf <= a0_in;
        a1_buf <= a1_in;
        idx    <= '0;
      end else if (state_q == RUN) begin
        for (int j = 0; j < LANES; j++) begin
          a_out[32*(base + j) +: 32] <= lane_sum[j];
        end
        idx <= last_step ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef P2R_RANGE_CHECK_EN
  localparam int Q      = 8380417;
  localparam int A1_MAX = (Q - 1) >> D;
  localparam int A0_MIN = -((1 << (D - 1)) - 1);
  localparam int A0_MAX = 1 << (D - 1);

  logic [LANES-1:0] lane_bad;
  logic             err_q;

  // A lane is bad when its a1 falls outside [0, (Q-1)>>D], or when its a0
  // falls outside the centred remainder range that Power2Round produces.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_bad[j] = (lane_a1[j] < 0) || (lane_a1[j] > A1_MAX) ||
                    (lane_a0[j] < A0_MIN) || (lane_a0[j] > A0_MAX);
    end
  end

  // The error flag is sticky across one polynomial and is cleared when the
  // next pair is accepted. It is only presented while the result is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == RUN && |lane_bad) begin
      err_q <= 1'b1;
    end
  end

  assign range_err = (state_q == DONE) && err_q;
`endif

endmodule

// File: tb/tb_poly_power2round_recombine.sv
// tb_poly_power2round_recombine
//
// Directed bench for poly_power2round_recombine at its default parameters
// (N=256, LANES=8, D=13). It steps through the following cases in order:
// reset values, an all-zero polynomial, boundary coefficients, a
// split/recombine round trip, backpressure in DONE, and reset in the middle
// of RUN. When P2R_RANGE_CHECK_EN is defined it also covers the range-error
// flag.

module tb_poly_power2round_recombine;

  localparam int N       = 256;
  localparam int LATENCY = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [32*N-1:0] a0_in;
  logic [32*N-1:0] a1_in;
  logic            out_valid;
  logic            out_ready;
  logic [32*N-1:0] a_out;
  logic            busy;
`ifdef P2R_RANGE_CHECK_EN
  logic            range_err;
`endif

  int vectors;
  int miscompares;

  logic [32*N-1:0] a0v;
  logic [32*N-1:0] a1v;
  logic [32*N-1:0] expv;
  logic [32*N-1:0] held;

  poly_power2round_recombine #(.N(N), .LANES(8), .D(13)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0_in     (a0_in),
    .a1_in     (a1_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .busy      (busy)
`ifdef P2R_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  // 10 ns clock with rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge, so sampling stays away
  // from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares one 32-bit value and logs it as a single vector.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compares a whole packed bus. The first differing coefficient (or
  // coefficient 0 if none differ) is reported as a single vector.
  task automatic checkBus(input string tag, input logic [32*N-1:0] observed,
                          input logic [32*N-1:0] expected);
    int k;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (observed[32*i +: 32] !== expected[32*i +: 32]) k = i;
    end
    checkOutput($sformatf("%s[%0d]", tag, k), observed[32*k +: 32],
                expected[32*k +: 32]);
  endtask

  // Presents a pair for one accept edge, then drops in_valid.
  task automatic applyStimulus(input logic [32*N-1:0] a0,
                               input logic [32*N-1:0] a1);
    a0_in    = a0;
    a1_in    = a1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid, with a bounded wait.
  // Also counts any sample taken before DONE at which busy was low.
  task automatic waitDone(output int cycles, output int busy_low);
    cycles   = 0;
    busy_low = (busy !== 1'b1) ? 1 : 0;
    while (out_valid !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  // Completes the output handshake and checks the return to IDLE.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_ov_after_hs"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ir_after_hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Power2Round split of a non-negative a: a0 is centred in (-4096, 4096].
  function automatic void split(input int a, output int a1, output int a0);
    a0 = a & 8191;
    if (a0 > 4096) a0 = a0 - 8192;
    a1 = (a - a0) >>> 13;
  endfunction

  initial begin
    int cycles;
    int busy_low;
    int viol;
    int pulses;
    int a;
    int s1;
    int s0;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a0_in       = '0;
    a1_in       = '0;

    // Reset values while reset is asserted.
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkBus("rst_a_out", a_out, '0);
    #1 rst_n = 1'b1;
    step();

    // All-zero polynomial: result after 32 cycles, with busy held the whole way.
    a0v = '0;
    a1v = '0;
    applyStimulus(a0v, a1v);
    checkOutput("zero_in_ready_run", {31'd0, in_ready}, 32'd0);
    waitDone(cycles, busy_low);
    checkOutput("zero_latency", cycles, LATENCY);
    checkOutput("zero_busy_low", busy_low, 32'd0);
    checkBus("zero_a_out", a_out, '0);
    handshake("zero");

    // Boundary coefficients at the edges of the legal ranges.
    a0v = '0;
    a1v = '0;
    a1v[32*0 +: 32]   = 32'd1023;
    a0v[32*0 +: 32]   = -32'sd4095;
    a1v[32*255 +: 32] = 32'd1;
    a0v[32*255 +: 32] = 32'd4096;
    a0v[32*7 +: 32]   = 32'hFFFF_FFFF;
    applyStimulus(a0v, a1v);
    waitDone(cycles, busy_low);
    checkOutput("bnd_latency", cycles, LATENCY);
    checkOutput("bnd_a0", a_out[32*0 +: 32], 32'd8376321);
    checkOutput("bnd_a255", a_out[32*255 +: 32], 32'd12288);
    checkOutput("bnd_a7", a_out[32*7 +: 32], 32'hFFFF_FFFF);
    expv = '0;
    expv[32*0 +: 32]   = 32'd8376321;
    expv[32*255 +: 32] = 32'd12288;
    expv[32*7 +: 32]   = 32'hFFFF_FFFF;
    checkBus("bnd_bus", a_out, expv);
`ifdef P2R_RANGE_CHECK_EN
    checkOutput("bnd_range_err", {31'd0, range_err}, 32'd0);
`endif
    handshake("bnd");

    // Round trip: split known values plus random ones, recombine, and compare.
    for (int i = 0; i < N; i++) begin
      case (i)
        0:       a = 0;
        1:       a = 4096;
        2:       a = 4097;
        3:       a = 8380416;
        default: a = int'($urandom_range(8380416, 0));
      endcase
      split(a, s1, s0);
      expv[32*i +: 32] = a;
      a1v[32*i +: 32]  = s1;
      a0v[32*i +: 32]  = s0;
    end
    applyStimulus(a0v, a1v);
    waitDone(cycles, busy_low);
    checkOutput("rt_latency", cycles, LATENCY);
    checkBus("rt_a_out", a_out, expv);

    // Backpressure: hold DONE with inputs toggling. The result must not move.
    held = a_out;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a0_in    = {N{$urandom()}};
      step();
      if (a_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) viol++;
    end
    checkOutput("bp_hold_violations", viol, 32'd0);
    checkBus("bp_a_out", a_out, expv);

    // Release: in_ready comes back the cycle after the handshake, and the
    // pair still on the bus is accepted on the following edge.
    for (int k = 0; k < N; k++) begin
      a1v[32*k +: 32]  = k;
      a0v[32*k +: 32]  = -k;
      expv[32*k +: 32] = k * 8191;
    end
    a0_in     = a0v;
    a1_in     = a1v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_ov_after_hs", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_ir_after_hs", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_second_busy", {31'd0, busy}, 32'd1);
    waitDone(cycles, busy_low);
    checkOutput("bp_second_latency", cycles, LATENCY);
    checkBus("bp_second_a_out", a_out, expv);
    handshake("bp2");

    // Reset while idx=10 in RUN: everything clears at once, and no stray
    // out_valid appears afterwards.
    applyStimulus(a0v, a1v);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkBus("mid_rst_a_out", a_out, '0);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) pulses++;
    end
    checkOutput("mid_rst_no_pulse", pulses, 32'd0);
    applyStimulus(a0v, a1v);
    waitDone(cycles, busy_low);
    checkOutput("mid_rst_next_latency", cycles, LATENCY);
    checkBus("mid_rst_next_a_out", a_out, expv);
    handshake("mid");

`ifdef P2R_RANGE_CHECK_EN
    // Out-of-range a1 sets the flag, but the arithmetic is still applied.
    a0v = '0;
    a1v = '0;
    a1v[32*100 +: 32] = 32'd1024;
    applyStimulus(a0v, a1v);
    waitDone(cycles, busy_low);
    checkOutput("rc_range_err_set", {31'd0, range_err}, 32'd1);
    checkOutput("rc_a100", a_out[32*100 +: 32], 32'd8388608);
    handshake("rc");
    a1v[32*100 +: 32] = 32'd1023;
    applyStimulus(a0v, a1v);
    waitDone(cycles, busy_low);
    checkOutput("rc_range_err_clear", {31'd0, range_err}, 32'd0);
    handshake("rc2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
